sfilt_seq: RTL

Command sequencer that drives the sfilt MAC engine. It is the initiator side of the cmd/q/h/pushin interface.
- Accepts one signed 32-bit sample at a time.
- Keeps an NTAPS-deep sample delay line and an NTAPS-entry coefficient bank.
- For each sample, emits the full command stream to the engine: first mult, mult-accumulates, shift-round, output/clear.
- Sits between the sample source and sfilt; sfilt's pushout/z return directly to the consumer.

---
 rtl/sfilt_seq_if.sv | 27 ++
 rtl/sfilt_seq.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sfilt_seq_if.sv
// Sample/coefficient input and MAC command output bundle of the sfilt sequencer.
// master = sample source / command consumer side, slave = sfilt_seq itself.
interface sfilt_seq_if #(
    parameter int AW = 6
);
    logic          pushin;
    logic [31:0]   din;
    logic          ready;
    logic [6:0]    shamt;
    logic          cwe;
    logic [AW-1:0] caddr;
    logic [31:0]   cdata;
    logic          cmd_push;
    logic [1:0]    cmd;
    logic [31:0]   q;
    logic [31:0]   h;

    modport master (
        output pushin, din, shamt, cwe, caddr, cdata,
        input  ready, cmd_push, cmd, q, h
    );

    modport slave (
        input  pushin, din, shamt, cwe, caddr, cdata,
        output ready, cmd_push, cmd, q, h
    );
endinterface

// File: rtl/sfilt_seq.sv
// Command sequencer for the sfilt MAC engine: one sample in, NTAPS+2 commands out.
// Optional SFILT_SEQ_SKIPZERO_EN drops MAC commands whose coefficient is zero.
module sfilt_seq #(
    parameter int NTAPS = 8,
    parameter int AW    = 6
) (
    input  logic       clk,
    input  logic       rst,
    sfilt_seq_if.slave bus
);
    localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int KW = $clog2(NTAPS + 1);

    // State names the command currently presented on cmd/q/h.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FIRST = 3'd1,
        MAC   = 3'd2,
        SHIFT = 3'd3,
        OUT   = 3'd4
    } state_t;

    state_t        r_state;
    logic [31:0]   r_x [NTAPS];
    logic [31:0]   r_c [NTAPS];
    logic [6:0]    r_sh;
    logic [KW-1:0] r_k;
    logic          r_cmd_push;
    logic [1:0]    r_cmd;
    logic [31:0]   r_q;
    logic [31:0]   r_h;

    logic             w_ready;
    logic             w_accept;
    logic             w_cwr;
    logic [31:0]      w_c0;
    logic [NTAPS-1:0] w_nz;
    logic [KW-1:0]    w_start;
    logic             w_found;
    logic [IW-1:0]    w_idx;

    assign w_ready  = (r_state == IDLE) || (r_state == OUT);
    assign w_accept = bus.pushin && w_ready;
    assign w_cwr    = bus.cwe && (r_state == IDLE) &&
                      ({1'b0, bus.caddr} < (AW + 1)'(NTAPS));
    // A write landing on the accept edge must already feed the first command.
    assign w_c0     = (w_cwr && (bus.caddr == '0)) ? bus.cdata : r_c[0];

    generate
        for (genvar gi = 0; gi < NTAPS; gi++) begin : g_tap
`ifdef SFILT_SEQ_SKIPZERO_EN
            assign w_nz[gi] = (r_c[gi] != 32'd0);
`else
            assign w_nz[gi] = 1'b1;
`endif

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_c[gi] <= 32'd0;
                end else if (w_cwr && (bus.caddr == AW'(gi))) begin
                    r_c[gi] <= bus.cdata;
                end
            end

            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_x[gi] <= 32'd0;
                    end else if (w_accept) begin
                        r_x[gi] <= bus.din;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (rst) begin
                        r_x[gi] <= 32'd0;
                    end else if (w_accept) begin
                        r_x[gi] <= r_x[gi-1];
                    end
                end
            end
        end
    endgenerate

    // Lowest tap at or above w_start that must be issued.
    always_comb begin
        w_start = (r_state == FIRST) ? KW'(1) : r_k;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = NTAPS - 1; i >= 0; i--) begin
            if ((KW'(i) >= w_start) && w_nz[i]) begin
                w_found = 1'b1;
                w_idx   = IW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh <= 7'd0;
        end else if (w_accept) begin
            r_sh <= bus.shamt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_k        <= '0;
            r_cmd_push <= 1'b0;
            r_cmd      <= 2'd0;
            r_q        <= 32'd0;
            r_h        <= 32'd0;
        end else begin
            case (r_state)
                IDLE, OUT: begin
                    if (w_accept) begin
                        r_state    <= FIRST;
                        r_cmd_push <= 1'b1;
                        r_cmd      <= 2'd0;
                        r_q        <= bus.din;
                        r_h        <= w_c0;
                    end else begin
                        r_state    <= IDLE;
                        r_cmd_push <= 1'b0;
                        r_cmd      <= 2'd0;
                        r_q        <= 32'd0;
                        r_h        <= 32'd0;
                    end
                end
                FIRST, MAC: begin
                    r_cmd_push <= 1'b1;
                    if (w_found) begin
                        r_state <= MAC;
                        r_cmd   <= 2'd1;
                        r_q     <= r_x[w_idx];
                        r_h     <= r_c[w_idx];
                        r_k     <= KW'(w_idx) + KW'(1);
                    end else begin
                        r_state <= SHIFT;
                        r_cmd   <= 2'd2;
                        r_q     <= 32'd0;
                        r_h     <= {25'd0, r_sh};
                    end
                end
                SHIFT: begin
                    r_state    <= OUT;
                    r_cmd_push <= 1'b1;
                    r_cmd      <= 2'd3;
                    r_q        <= 32'd0;
                    r_h        <= 32'd0;
                end
                default: begin
                    r_state    <= IDLE;
                    r_cmd_push <= 1'b0;
                    r_cmd      <= 2'd0;
                    r_q        <= 32'd0;
                    r_h        <= 32'd0;
                end
            endcase
        end
    end

    assign bus.ready    = w_ready;
    assign bus.cmd_push = r_cmd_push;
    assign bus.cmd      = r_cmd;
    assign bus.q        = r_q;
    assign bus.h        = r_h;
endmodule
